wino_tile_gen_3x3: RTL
======================

// Module: wino_tile_gen_3x3
// PURPOSE
//  Upstream feeder for the Winograd BT*D*B input-transform stage. Accepts a
//  raster-order (row-major) pixel stream of one IMG_W x IMG_H feature-map plane.
//  Buffers two previous rows and emits overlapping 3x3 tiles at stride 2
//  (overlap 1) on a valid/ready interface. tile0..tile8 map 1:1 onto din0..din8.
// PARAMETERS
//  data_width  18  pixel / tile element width, bits
//  IMG_W        9  plane width in pixels; odd, >= 3
//  IMG_H        9  plane height in pixels; odd, >= 3
// PORTS
//  clk          in   1           single clock; all state on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  pix_in       in   data_width  input pixel
//  pix_valid    in   1           pix_in valid
//  pix_ready    out  1           block can accept pix_in this cycle
//  tile0..tile8 out  data_width  3x3 tile, row-major (tile0 = top-left, tile8 = bottom-right)
//  tile_valid   out  1           tile0..8 valid
//  tile_ready   in   1           downstream accepts tile
//  tile_last    out  1           qualifies tile_valid; last tile of the plane
// BEHAVIOUR
//  Reset (async assert, sync release): tile_valid=0, tile_last=0, tile0..8=0,
//   col=0, row=0. Line-buffer RAM contents are not reset.
//  Transfer rules
//   - Pixel accepted when pix_valid && pix_ready.
//   - Tile consumed when tile_valid && tile_ready.
//   - pix_ready = !tile_valid || tile_ready (combinational). Pixel accept and
//     tile consume in the same cycle is legal.
//  Counters
//   - col advances 0..IMG_W-1 per accepted pixel; wraps to 0 and increments row.
//   - row advances 0..IMG_H-1; wraps to 0 after pixel (IMG_W-1, IMG_H-1).
//   - Wrap to the next plane needs no idle cycle.
//  Storage
//   - lb1[col] holds row-1; lb2[col] holds row-2.
//   - On accept at col c: lb2[c] <= lb1[c]; lb1[c] <= pix_in.
//   - 3x3 window shift register: 3 rows x 3 cols. Each accept shifts in the
//     column {lb2[c], lb1[c], pix_in}.
//  Tile emit
//   - Trigger: pixel accepted with row>=2, row even, col>=2, col even.
//   - Next cycle: tile_valid=1 and tile0..8 = rows (row-2..row) x cols (col-2..col).
//   - Latency: 1 cycle after the completing pixel is accepted.
//   - tile_last=1 only for the tile triggered by (IMG_W-1, IMG_H-1).
//   - Tiles per plane: ((IMG_W-1)/2) * ((IMG_H-1)/2).
//  Output hold
//   - While tile_valid && !tile_ready: tile0..8 and tile_last hold stable and
//     pix_ready=0, so no pixel is lost and no tile is dropped.
//   - On consume with no new trigger: tile_valid=0 next cycle.
//   - On consume with a new trigger in the same cycle: tile_valid stays 1 with
//     the new tile.
//  Other boundaries
//   - Row 0/1 and col 0/1 never trigger.
//   - Stale line-buffer data from a previous plane is always overwritten before use.
//  Arithmetic: no data arithmetic; pixels are passed bit-exact.
//   Counter widths = $clog2(IMG_W), $clog2(IMG_H).
//  Reset mid-plane: partial plane discarded and pending tile dropped. The next
//   accepted pixel is taken as (0,0) of a new plane.
// TESTING (IMG_W=5, IMG_H=5, pixels = 0..24 in order, tile_ready=1)
//  1. Stream 0..24 back-to-back -> exactly 4 tiles:
//     - {0,1,2,5,6,7,10,11,12} one cycle after pixel 12
//     - {2,3,4,7,8,9,12,13,14}
//     - {10,11,12,15,16,17,20,21,22}
//     - {12,13,14,17,18,19,22,23,24} with tile_last=1; tile_last=0 on the others
//  2. Hold tile_ready=0 for 5 cycles at the first tile -> pix_ready=0, tile
//     {0,1,..,12} stable, no pixel accepted; release -> remaining 3 tiles correct.
//  3. Random pix_valid gaps and random tile_ready -> same 4 tiles in order,
//     no duplicates or drops.
//  4. Two planes back-to-back (second = 100..124) -> second plane tiles are
//     {100,101,102,105,106,107,110,111,112} ... with no contamination from plane 1.
//  5. Assert rst_n=0 after pixel 13 while a tile is pending -> tile_valid=0
//     immediately; restart 0..24 -> test 1 sequence reproduced exactly.
//  6. Reset values: after rst_n deassert, tile_valid=0, tile_last=0, all
//     tile0..8=0, pix_ready=1.

Source files
------------

// File: rtl/wino_tile_gen_3x3_if.sv
// Pixel-in / tile-out handshake bundle for the 3x3 Winograd tile generator.
// The master side drives pixels and tile_ready; the slave side is the generator.
interface wino_tile_gen_3x3_if #(
    parameter int unsigned data_width = 18
);
    logic [data_width-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [data_width-1:0] tile0, tile1, tile2, tile3, tile4, tile5, tile6, tile7, tile8;
    logic                  tile_valid;
    logic                  tile_ready;
    logic                  tile_last;

    modport master (
        output pix_in, pix_valid, tile_ready,
        input  pix_ready, tile0, tile1, tile2, tile3, tile4, tile5, tile6, tile7, tile8,
        input  tile_valid, tile_last
    );

    modport slave (
        input  pix_in, pix_valid, tile_ready,
        output pix_ready, tile0, tile1, tile2, tile3, tile4, tile5, tile6, tile7, tile8,
        output tile_valid, tile_last
    );
endinterface

// File: rtl/wino_tile_gen_3x3.sv
// Raster-order pixel stream to overlapping 3x3 tiles (stride 2) for the Winograd
// input transform; two line buffers plus a 3x3 shift window.
module wino_tile_gen_3x3 #(
    parameter int unsigned data_width = 18,
    parameter int unsigned IMG_W      = 9,
    parameter int unsigned IMG_H      = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    wino_tile_gen_3x3_if.slave io_bus
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [data_width-1:0] r_lb1 [IMG_W];
    logic [data_width-1:0] r_lb2 [IMG_W];
    logic [data_width-1:0] r_win [3][3];
    logic                  r_tile_valid;
    logic                  r_tile_last;

    logic                  w_pix_ready;
    logic                  w_accept;
    logic                  w_col_end;
    logic                  w_row_end;
    logic                  w_trigger;
    logic [data_width-1:0] w_lb1_rd;
    logic [data_width-1:0] w_lb2_rd;

    assign w_pix_ready = !r_tile_valid || io_bus.tile_ready;
    assign w_accept    = io_bus.pix_valid && w_pix_ready;
    assign w_col_end   = (r_col == CW'(IMG_W - 1));
    assign w_row_end   = (r_row == RW'(IMG_H - 1));
    assign w_trigger   = w_accept && (r_row >= RW'(2)) && !r_row[0]
                      && (r_col >= CW'(2)) && !r_col[0];
    assign w_lb1_rd    = r_lb1[r_col];
    assign w_lb2_rd    = r_lb2[r_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers are never reset: every entry is rewritten before a tile reads it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= io_bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb2_rd;
            r_win[1][2] <= w_lb1_rd;
            r_win[2][2] <= io_bus.pix_in;
        end
    end

    // The window doubles as the output register: it only moves on accept, and
    // accept is blocked while a tile is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile_valid <= 1'b0;
            r_tile_last  <= 1'b0;
        end else if (w_trigger) begin
            r_tile_valid <= 1'b1;
            r_tile_last  <= w_col_end && w_row_end;
        end else if (io_bus.tile_ready) begin
            r_tile_valid <= 1'b0;
            r_tile_last  <= 1'b0;
        end
    end

    assign io_bus.pix_ready  = w_pix_ready;
    assign io_bus.tile_valid = r_tile_valid;
    assign io_bus.tile_last  = r_tile_last;
    assign io_bus.tile0      = r_win[0][0];
    assign io_bus.tile1      = r_win[0][1];
    assign io_bus.tile2      = r_win[0][2];
    assign io_bus.tile3      = r_win[1][0];
    assign io_bus.tile4      = r_win[1][1];
    assign io_bus.tile5      = r_win[1][2];
    assign io_bus.tile6      = r_win[2][0];
    assign io_bus.tile7      = r_win[2][1];
    assign io_bus.tile8      = r_win[2][2];
endmodule
